video_console_writer: RTL and testbench
=======================================

VIDEO_CONSOLE_WRITER -- requirements
Module: video_console_writer

Interface
REQ-001 Parameter TW, default 80, console width in characters.
REQ-002 Parameter TH, default 2, console height in characters.
REQ-003 Parameter CMAW, default 8, console memory address width; TW*TH SHALL be at most 2^CMAW.
REQ-004 Parameter CMDW, default 8, console memory data width.
REQ-005 Parameter BLANK, default 8'h20, fill code written when clearing.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 clk_en  in  1  clock enable; all state advances only on clk edges with clk_en=1.
REQ-009 in_valid  in  1  input character valid.
REQ-010 in_ready  out  1  writer can accept a character; combinational, equals (state==IDLE && !clr).
REQ-011 in_dat  in  8  input character code.
REQ-012 clr  in  1  clear-screen request, level-sampled.
REQ-013 busy  out  1  high in any clear state.
REQ-014 cur_col  out  $clog2(TW)  cursor column.
REQ-015 cur_row  out  $clog2(TH)  cursor row.
REQ-016 con_we  out  1  console memory write enable, registered.
REQ-017 con_adr_w  out  CMAW  console memory write address, registered.
REQ-018 con_dat_w  out  CMDW  console memory write data, registered.

Function
REQ-019 States: IDLE, CLR_LINE, CLR_SCREEN; a character is accepted on an enabled edge with in_valid && in_ready.
REQ-020 Write latency: accepted character at enabled edge N SHALL produce con_we=1, with address and data, after edge N, held for exactly one enabled cycle.
REQ-021 Address = row_base + col, where row_base is a register stepped by TW per row; no multiplier.
REQ-022 Codes 0x20-0x7E and 0x80-0xFF SHALL be written at the cursor, then col increments.
REQ-023 Writing at col TW-1 SHALL set col=0, advance row (TH-1 wraps to 0), and enter CLR_LINE for the new row.
REQ-024 0x0A SHALL set col=0, advance row with wrap, and enter CLR_LINE; no character is written.
REQ-025 0x0D SHALL set col=0 with no write.
REQ-026 0x08 SHALL decrement col if col>0, with no write; col stays 0 at 0.
REQ-027 0x0C SHALL home the cursor to (0,0) and enter CLR_SCREEN.
REQ-028 Other control codes (0x00-0x1F not listed above, and 0x7F) SHALL be consumed with no write and no cursor change.
REQ-029 CLR_LINE SHALL write BLANK to row_base..row_base+TW-1, one write per enabled cycle, then return to IDLE.
REQ-030 CLR_SCREEN SHALL write BLANK to 0..TW*TH-1, one write per enabled cycle, set cursor to (0,0), then return to IDLE.
REQ-031 clr=1 in any state SHALL enter CLR_SCREEN at address 0 on the next enabled edge, aborting or restarting any clear; clr has priority over in_valid.
REQ-032 With clk_en=0, all registers and outputs SHALL hold.
REQ-033 The consumer's con_clk_en_w is tied to the same clk_en.

Reset
REQ-034 On rst, state SHALL be CLR_SCREEN with clear address 0, and busy=1.
REQ-035 On rst, con_we=0, con_adr_w=0, con_dat_w=0, cur_col=0 and cur_row=0.
REQ-036 Release of rst SHALL start an automatic full-screen clear; in_ready=0 until that clear completes.
REQ-037 rst asserted mid-clear or mid-write SHALL cancel the pending write immediately.

Structure
REQ-038 Character code constants (0x08, 0x0A, 0x0C, 0x0D, 0x20, 0x7F) and the state encodings SHALL reside in the shared video definitions include.
REQ-039 No sub-module: single flat module with one FSM, col/row counters, a row_base register and a clear-address counter.

Verification (TW=80, TH=2)
REQ-040 Release rst -> 160 writes of 0x20 to adr 0..159 on consecutive cycles, busy=1 throughout, then in_ready=1 and cursor (0,0).
REQ-041 Send 0x41 then 0x42 -> con_we at adr 0 dat 0x41, then adr 1 dat 0x42; cursor (2,0).
REQ-042 Send 80 printables -> last at adr 79, then 80 BLANK writes to adr 80..159 with in_ready=0; next char lands at adr 80.
REQ-043 Cursor on row 1 col 5, send 0x0A -> BLANK writes to adr 0..79; cursor (0,0); next char at adr 0. 0x08 at col 0 -> no write; 0x0D at col 7 -> col 0, no write.
REQ-044 Assert clr during CLR_LINE at adr 85 -> writes restart at adr 0 and cover 0..159 exactly once; clr together with in_valid -> character not accepted.
REQ-045 clk_en toggling 1-of-3 during REQ-041/042 -> identical write sequence, outputs stable on disabled cycles.

Source files
------------

// File: rtl/video_console_writer_pkg.sv
// Shared video definitions: console character codes and writer state encodings.
package video_console_writer_pkg;

   localparam logic [7:0] CH_BS  = 8'h08;
   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_FF  = 8'h0C;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_SP  = 8'h20;
   localparam logic [7:0] CH_DEL = 8'h7F;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CLR_LINE   = 2'd1,
      ST_CLR_SCREEN = 2'd2
   } wr_state_e;

   // Everything from space upward is drawn, including the upper half; only DEL is not.
   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_SP) && (c != CH_DEL);
   endfunction

endpackage

// File: rtl/video_console_writer.sv
// Character console writer: turns a character stream into console-memory writes,
// tracking the cursor and blanking lines/screen as needed.
//
// state         | meaning
// ST_IDLE       | waiting for a character
// ST_CLR_LINE   | blanking the row the cursor just moved to
// ST_CLR_SCREEN | blanking the whole console, cursor homed
module video_console_writer #(
   parameter int                TW    = 80,
   parameter int                TH    = 2,
   parameter int                CMAW  = 8,
   parameter int                CMDW  = 8,
   parameter logic [CMDW-1:0]   BLANK = CMDW'(8'h20)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_dat,
   input  logic                    clr,
   output logic                    busy,
   output logic [$clog2(TW)-1:0]   cur_col,
   output logic [$clog2(TH)-1:0]   cur_row,
   output logic                    con_we,
   output logic [CMAW-1:0]         con_adr_w,
   output logic [CMDW-1:0]         con_dat_w
);
   import video_console_writer_pkg::*;

   localparam int CW = $clog2(TW);
   localparam int RW = $clog2(TH);
   localparam logic [CW-1:0]   COL_LAST  = CW'(TW - 1);
   localparam logic [RW-1:0]   ROW_LAST  = RW'(TH - 1);
   localparam logic [CMAW-1:0] ROW_STEP  = CMAW'(TW);
   localparam logic [CMAW-1:0] LINE_SPAN = CMAW'(TW - 1);
   localparam logic [CMAW-1:0] SCR_LAST  = CMAW'(TW * TH - 1);

   wr_state_e       state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CMAW-1:0] base_q, base_d;
   logic [CMAW-1:0] clr_adr_q, clr_adr_d;
   logic            we_q, we_d;
   logic [CMAW-1:0] adr_q, adr_d;
   logic [CMDW-1:0] dat_q, dat_d;

   logic [RW-1:0]   row_nxt;
   logic [CMAW-1:0] base_nxt;

   assign in_ready  = (state_q == ST_IDLE) && !clr;
   assign busy      = (state_q != ST_IDLE);
   assign cur_col   = col_q;
   assign cur_row   = row_q;
   assign con_we    = we_q;
   assign con_adr_w = adr_q;
   assign con_dat_w = dat_q;

   // Row base tracks row*TW incrementally so the address needs only an adder.
   always_comb begin
      row_nxt  = row_q + 1'b1;
      base_nxt = base_q + ROW_STEP;
      if (row_q == ROW_LAST) begin
         row_nxt  = '0;
         base_nxt = '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      base_d    = base_q;
      clr_adr_d = clr_adr_q;
      we_d      = 1'b0;
      adr_d     = adr_q;
      dat_d     = dat_q;

      if (clr) begin
         state_d   = ST_CLR_SCREEN;
         clr_adr_d = '0;
         col_d     = '0;
         row_d     = '0;
         base_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  if (is_printable(in_dat)) begin
                     we_d  = 1'b1;
                     adr_d = base_q + CMAW'(col_q);
                     dat_d = CMDW'(in_dat);
                     if (col_q == COL_LAST) begin
                        col_d     = '0;
                        row_d     = row_nxt;
                        base_d    = base_nxt;
                        clr_adr_d = base_nxt;
                        state_d   = ST_CLR_LINE;
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                  end else begin
                     case (in_dat)
                        CH_LF: begin
                           col_d     = '0;
                           row_d     = row_nxt;
                           base_d    = base_nxt;
                           clr_adr_d = base_nxt;
                           state_d   = ST_CLR_LINE;
                        end
                        CH_CR: col_d = '0;
                        CH_BS: if (col_q != '0) col_d = col_q - 1'b1;
                        CH_FF: begin
                           col_d     = '0;
                           row_d     = '0;
                           base_d    = '0;
                           clr_adr_d = '0;
                           state_d   = ST_CLR_SCREEN;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            ST_CLR_LINE: begin
               we_d  = 1'b1;
               adr_d = clr_adr_q;
               dat_d = BLANK;
               if (clr_adr_q == base_q + LINE_SPAN) state_d = ST_IDLE;
               else clr_adr_d = clr_adr_q + 1'b1;
            end
            ST_CLR_SCREEN: begin
               we_d  = 1'b1;
               adr_d = clr_adr_q;
               dat_d = BLANK;
               if (clr_adr_q == SCR_LAST) begin
                  state_d = ST_IDLE;
                  col_d   = '0;
                  row_d   = '0;
                  base_d  = '0;
               end else begin
                  clr_adr_d = clr_adr_q + 1'b1;
               end
            end
            default: state_d = ST_CLR_SCREEN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_CLR_SCREEN;
         col_q     <= '0;
         row_q     <= '0;
         base_q    <= '0;
         clr_adr_q <= '0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
      end else if (clk_en) begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         base_q    <= base_d;
         clr_adr_q <= clr_adr_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
      end
   end

endmodule

// File: tb/tb_video_console_writer.sv
// Directed bench for video_console_writer at TW=80, TH=2.
module tb_video_console_writer;

   logic       clk = 1'b0;
   logic       rst, clk_en, in_valid, clr;
   logic [7:0] in_dat;
   logic       in_ready, busy;
   logic [6:0] cur_col;
   logic [0:0] cur_row;
   logic       con_we;
   logic [7:0] con_adr_w, con_dat_w;

   int  n_chk = 0;
   int  n_bad = 0;
   bit  slow  = 1'b0;
   logic [15:0] wq[$];
   logic [15:0] eq[$];

   video_console_writer dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_dat(in_dat),
      .clr(clr), .busy(busy), .cur_col(cur_col), .cur_row(cur_row),
      .con_we(con_we), .con_adr_w(con_adr_w), .con_dat_w(con_dat_w)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] snap();
      return {6'd0, con_we, con_adr_w, con_dat_w, cur_col, cur_row, busy};
   endfunction

   // One enabled edge; in slow mode preceded by two disabled edges that must change nothing.
   task automatic step();
      logic [31:0] s;
      if (slow) begin
         repeat (2) begin
            clk_en = 1'b0;
            s = snap();
            @(posedge clk); #1;
            check_val("hold", snap(), s);
         end
      end
      clk_en = 1'b1;
      @(posedge clk); #1;
      if (con_we) wq.push_back({con_adr_w, con_dat_w});
   endtask

   task automatic drain(output int n);
      n = 0;
      while (!in_ready && n < 400) begin
         step();
         n++;
      end
      if (!in_ready) check_val("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [7:0] c);
      int n;
      drain(n);
      in_valid = 1'b1;
      in_dat   = c;
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_seq(input string tag);
      check_val({tag, "_n"}, wq.size(), eq.size());
      for (int i = 0; i < eq.size() && i < wq.size(); i++) check_val(tag, wq[i], eq[i]);
      wq.delete();
      eq.delete();
   endtask

   task automatic run_seq(input string tag);
      int n;
      logic [7:0] c;
      send(8'h0C);
      drain(n);
      check_val("ff_clr_len", n, 160);
      wq.delete();
      eq.delete();
      send(8'h41);
      send(8'h42);
      eq.push_back({8'd0, 8'h41});
      eq.push_back({8'd1, 8'h42});
      check_val("col_ab", cur_col, 2);
      check_val("row_ab", cur_row, 0);
      send(8'h0D);
      check_val("col_cr", cur_col, 0);
      for (int i = 0; i < 80; i++) begin
         c = 8'h30 + 8'(i % 40);
         send(c);
         eq.push_back({i[7:0], c});
      end
      check_val("wrap_ready", in_ready, 0);
      check_val("wrap_busy", busy, 1);
      check_val("wrap_col", cur_col, 0);
      check_val("wrap_row", cur_row, 1);
      drain(n);
      check_val("line_clr_len", n, 80);
      for (int i = 80; i < 160; i++) eq.push_back({i[7:0], 8'h20});
      send(8'h5A);
      eq.push_back({8'd80, 8'h5A});
      check_val("after_wrap_col", cur_col, 1);
      check_val("after_wrap_row", cur_row, 1);
      check_seq(tag);
   endtask

   initial begin
      int n;
      rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0; clr = 1'b0; in_dat = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_we", con_we, 0);
      check_val("rst_adr", con_adr_w, 0);
      check_val("rst_dat", con_dat_w, 0);
      check_val("rst_col", cur_col, 0);
      check_val("rst_row", cur_row, 0);
      check_val("rst_busy", busy, 1);
      check_val("rst_ready", in_ready, 0);
      rst = 1'b0;

      for (int i = 0; i < 160; i++) begin
         step();
         check_val("boot_we", con_we, 1);
         check_val("boot_adr", con_adr_w, i);
         check_val("boot_dat", con_dat_w, 8'h20);
         check_val("boot_busy", busy, (i < 159) ? 1 : 0);
      end
      check_val("boot_ready", in_ready, 1);
      check_val("boot_col", cur_col, 0);
      check_val("boot_row", cur_row, 0);
      wq.delete();

      slow = 1'b0;
      run_seq("seq_fast");
      slow = 1'b1;
      run_seq("seq_slow");
      slow = 1'b0;

      // cursor (1,1) -> write four more to reach col 5 on row 1
      for (int i = 0; i < 4; i++) begin
         send(8'h61 + 8'(i));
         eq.push_back({8'd81 + 8'(i), 8'h61 + 8'(i)});
      end
      check_val("c5_col", cur_col, 5);
      send(8'h0A);
      drain(n);
      check_val("lf_clr_len", n, 80);
      for (int i = 0; i < 80; i++) eq.push_back({i[7:0], 8'h20});
      check_val("lf_col", cur_col, 0);
      check_val("lf_row", cur_row, 0);
      send(8'h43);
      eq.push_back({8'd0, 8'h43});
      send(8'h08);
      check_val("bs_col", cur_col, 0);
      send(8'h08);
      check_val("bs0_col", cur_col, 0);
      send(8'h07);
      send(8'h7F);
      check_val("ctl_col", cur_col, 0);
      send(8'hC1);
      eq.push_back({8'd0, 8'hC1});
      for (int i = 0; i < 6; i++) begin
         send(8'h31 + 8'(i));
         eq.push_back({8'd1 + 8'(i), 8'h31 + 8'(i)});
      end
      check_val("c7_col", cur_col, 7);
      send(8'h0D);
      check_val("cr7_col", cur_col, 0);
      check_val("cr7_row", cur_row, 0);
      check_seq("seq_ctl");

      // clear request in the middle of a line clear
      send(8'h0A);
      n = 0;
      while (!(con_we && con_adr_w == 8'd85) && n < 200) begin
         step();
         n++;
      end
      check_val("reach85", con_adr_w, 85);
      wq.delete();
      clr = 1'b1; in_valid = 1'b1; in_dat = 8'h55;
      #1;
      check_val("clr_ready", in_ready, 0);
      step();
      check_val("clr_abort_we", con_we, 0);
      check_val("clr_busy", busy, 1);
      clr = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 160; i++) begin
         step();
         check_val("clr_we", con_we, 1);
         check_val("clr_adr", con_adr_w, i);
         check_val("clr_dat", con_dat_w, 8'h20);
      end
      check_val("clr_done_ready", in_ready, 1);
      check_val("clr_done_col", cur_col, 0);
      check_val("clr_done_row", cur_row, 0);
      step();
      check_val("clr_no_extra", con_we, 0);
      wq.delete();

      // asynchronous reset in the middle of a screen clear
      send(8'h0C);
      step();
      step();
      check_val("pre_rst_we", con_we, 1);
      #1 rst = 1'b1;
      #1;
      check_val("async_rst_we", con_we, 0);
      check_val("async_rst_adr", con_adr_w, 0);
      check_val("async_rst_busy", busy, 1);
      rst = 1'b0;
      drain(n);
      check_val("post_rst_clr_len", n, 160);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
